// File: rtl/debug_pkg.sv
// Shared definitions for the debug run controller: command bytes, FSM states,
// the EOP opcode and the dump-length helper.
// Ports: none (package).
package debug_pkg;

  localparam logic [7:0] CMD_RUN     = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP    = 8'h73;  // 's'
  localparam logic [7:0] CMD_RESTART = 8'h72;  // 'r'

  localparam logic [5:0] EOP_OPCODE = 6'b111111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_PC,
    ST_DUMP_CYC,
    ST_DUMP_REG,
    ST_MEM_FETCH,
    ST_DUMP_MEM,
    ST_HALTED
  } state_t;

  // Bytes in one state dump: PC word, cycle-count word, registers, memory.
  function automatic int DUMP_BYTES(int num_regs, int num_mem_words, int word_w);
    return (word_w / 8) * (2 + num_regs + num_mem_words);
  endfunction

endpackage

// File: rtl/debug_run_controller_if.sv
// UART byte link between the debug controller and the host UART.
// Ports: rx_valid/rx_data (command byte in), tx_data/tx_valid/tx_ready (dump byte out).
// master = controller side, slave = UART side.
interface debug_run_controller_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (input rx_valid, rx_data, tx_ready, output tx_data, tx_valid);
  modport slave  (output rx_valid, rx_data, tx_ready, input tx_data, tx_valid);
endinterface

// File: rtl/dbg_word_serializer.sv
// Loads one word and emits it MSB byte first over a valid/ready handshake.
// Ports: clk, reset, load/word (new word, only when idle or on done),
// tx_data/tx_valid/tx_ready (byte stream), done (last byte transfers this cycle).
module dbg_word_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  localparam int NB = WORD_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     cnt;

  assign tx_data = shreg[WORD_W-1 -: 8];
  assign done    = tx_valid && tx_ready && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= word;
      cnt      <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      shreg <= shreg << 8;
      cnt   <= cnt + 1'b1;
      if (done) tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_run_controller.sv
// Debug sequencer: takes run/step/restart commands from the UART link, gates
// the MIPS pipeline via pipe_enable and streams PC, cycle count, registers and
// data memory back to the host after a step or when EOP retires.
// Ports: clk, reset, link (UART byte link), pipe_enable/pipe_reset (datapath
// control), eop_wb, pc_value, dbg_reg_* (comb read), dbg_mem_* (1-cycle read),
// busy/halted (status).
module debug_run_controller
  import debug_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 32,
  parameter int WORD_W        = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  debug_run_controller_if.master           link,
  output logic                             pipe_enable,
  output logic                             pipe_reset,
  input  logic                             eop_wb,
  input  logic [WORD_W-1:0]                pc_value,
  output logic [4:0]                       dbg_reg_addr,
  input  logic [WORD_W-1:0]                dbg_reg_data,
  output logic [$clog2(NUM_MEM_WORDS)-1:0] dbg_mem_addr,
  input  logic [WORD_W-1:0]                dbg_mem_data,
  output logic                             busy,
  output logic                             halted
);

  localparam int MEM_AW = $clog2(NUM_MEM_WORDS);
  localparam logic [4:0]        REG_LAST = 5'(NUM_REGS - 1);
  localparam logic [MEM_AW-1:0] MEM_LAST = MEM_AW'(NUM_MEM_WORDS - 1);

  state_t              state, next_state;
  logic [WORD_W-1:0]   cycle_cnt;
  logic                run_mode;
  logic                eop_seen;
  logic [4:0]          reg_idx;
  logic [MEM_AW-1:0]   mem_idx;

  logic                ser_load;
  logic [WORD_W-1:0]   ser_word;
  logic                ser_done;
  logic                restart;

  assign pipe_enable  = (state == ST_RUN) || (state == ST_STEP);
  assign busy         = (state != ST_IDLE) && (state != ST_HALTED);
  assign halted       = (state == ST_HALTED);
  assign dbg_reg_addr = reg_idx;
  assign dbg_mem_addr = mem_idx;

  // Restart is honoured only when not busy; in HALTED it is the only command.
  assign restart = link.rx_valid && (link.rx_data == CMD_RESTART) &&
                   ((state == ST_IDLE) || (state == ST_HALTED));

  dbg_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .word     (ser_word),
    .tx_data  (link.tx_data),
    .tx_valid (link.tx_valid),
    .tx_ready (link.tx_ready),
    .done     (ser_done)
  );

  // Each dump state loads its word the first cycle the serializer is empty and
  // leaves on the word's last byte, so the source address is stable for all
  // bytes of the word.
  always_comb begin
    next_state = state;
    ser_load   = 1'b0;
    ser_word   = '0;
    case (state)
      ST_IDLE: begin
        if (link.rx_valid) begin
          if (link.rx_data == CMD_RUN)       next_state = ST_RUN;
          else if (link.rx_data == CMD_STEP) next_state = ST_STEP;
        end
      end
      ST_RUN:  if (eop_wb) next_state = ST_DUMP_PC;
      ST_STEP: next_state = ST_DUMP_PC;
      ST_DUMP_PC: begin
        ser_load = !link.tx_valid;
        ser_word = pc_value;
        if (ser_done) next_state = ST_DUMP_CYC;
      end
      ST_DUMP_CYC: begin
        ser_load = !link.tx_valid;
        ser_word = cycle_cnt;
        if (ser_done) next_state = ST_DUMP_REG;
      end
      ST_DUMP_REG: begin
        ser_load = !link.tx_valid;
        ser_word = dbg_reg_data;
        if (ser_done && (reg_idx == REG_LAST)) next_state = ST_MEM_FETCH;
      end
      // Memory read is synchronous: present the address, consume next cycle.
      ST_MEM_FETCH: next_state = ST_DUMP_MEM;
      ST_DUMP_MEM: begin
        ser_load = !link.tx_valid;
        ser_word = dbg_mem_data;
        if (ser_done) begin
          if (mem_idx != MEM_LAST)        next_state = ST_MEM_FETCH;
          else if (eop_seen || run_mode)  next_state = ST_HALTED;
          else                            next_state = ST_IDLE;
        end
      end
      ST_HALTED: if (restart) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cycle_cnt  <= '0;
      run_mode   <= 1'b0;
      eop_seen   <= 1'b0;
      reg_idx    <= '0;
      mem_idx    <= '0;
      pipe_reset <= 1'b0;
    end else begin
      state      <= next_state;
      pipe_reset <= restart;

      if (restart)
        cycle_cnt <= '0;
      else if (pipe_enable && (cycle_cnt != '1))
        cycle_cnt <= cycle_cnt + 1'b1;

      if (restart) begin
        run_mode <= 1'b0;
        eop_seen <= 1'b0;
      end
      if ((state == ST_IDLE) && (next_state == ST_RUN)) run_mode <= 1'b1;
      if (pipe_enable && eop_wb) eop_seen <= 1'b1;

      if (state == ST_DUMP_PC) begin
        reg_idx <= '0;
        mem_idx <= '0;
      end
      if ((state == ST_DUMP_REG) && ser_done && (reg_idx != REG_LAST))
        reg_idx <= reg_idx + 1'b1;
      if ((state == ST_DUMP_MEM) && ser_done && (mem_idx != MEM_LAST))
        mem_idx <= mem_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed bench for debug_run_controller with a small datapath model:
// PC = 4, reg[i] = i, mem[j] = 0x100 + j (synchronous read).
module tb_debug_run_controller;
  import debug_pkg::*;

  localparam int WORD_W        = 32;
  localparam int NUM_REGS      = 32;
  localparam int NUM_MEM_WORDS = 32;
  localparam int NBYTES        = DUMP_BYTES(NUM_REGS, NUM_MEM_WORDS, WORD_W);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pipe_enable, pipe_reset, eop_wb, busy, halted;
  logic [WORD_W-1:0] pc_value, dbg_reg_data, dbg_mem_data;
  logic [4:0] dbg_reg_addr;
  logic [$clog2(NUM_MEM_WORDS)-1:0] dbg_mem_addr;

  debug_run_controller_if link();

  debug_run_controller #(
    .NUM_REGS(NUM_REGS), .NUM_MEM_WORDS(NUM_MEM_WORDS), .WORD_W(WORD_W)
  ) dut (
    .clk(clk), .reset(reset), .link(link),
    .pipe_enable(pipe_enable), .pipe_reset(pipe_reset), .eop_wb(eop_wb),
    .pc_value(pc_value), .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  assign pc_value     = 32'h0000_0004;
  assign dbg_reg_data = {27'd0, dbg_reg_addr};
  always @(posedge clk) dbg_mem_data <= 32'h100 + 32'(dbg_mem_addr);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // TX side: drive tx_ready at negedge, record bytes that will transfer at
  // the next posedge, and flag any change of a stalled byte.
  logic [7:0] txq[$];
  int ready_mode = 0;
  int stall_err  = 0;

  initial begin
    int   ph;
    logic pv, prst;
    logic [7:0] pd;
    ph = 0; pv = 1'b0; prst = 1'b1; pd = 8'h00;
    link.tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && !prst && pv && !link.tx_ready)
        if (!link.tx_valid || (link.tx_data !== pd)) stall_err++;
      link.tx_ready = (ready_mode == 0) ? 1'b1 : (ph == 0);
      ph = (ph == 2) ? 0 : ph + 1;
      if (link.tx_valid && link.tx_ready) txq.push_back(link.tx_data);
      pv = link.tx_valid; pd = link.tx_data; prst = reset;
    end
  end

  int pe_cnt = 0;
  int pr_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (pipe_enable) pe_cnt++;
    if (pipe_reset)  pr_cnt++;
  end

  // Main process acts just after each negedge, after the monitors.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    link.rx_valid = 1'b1;
    link.rx_data  = b;
    tick();
    link.rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_finished"}, busy, 1'b0);
  endtask

  function automatic logic [31:0] qword(input int w);
    return {txq[4*w], txq[4*w+1], txq[4*w+2], txq[4*w+3]};
  endfunction

  function automatic logic [7:0] exp_byte(input int k, input logic [31:0] cyc);
    int w;
    logic [31:0] v;
    w = k / 4;
    if (w == 0)                v = 32'h4;
    else if (w == 1)           v = cyc;
    else if (w < 2 + NUM_REGS) v = 32'(w - 2);
    else                       v = 32'h100 + 32'(w - 2 - NUM_REGS);
    return v[31 - 8*(k % 4) -: 8];
  endfunction

  task automatic check_dump(input string tag, input logic [31:0] cyc);
    int errs;
    errs = 0;
    chk({tag, "_nbytes"}, txq.size(), NBYTES);
    for (int k = 0; k < txq.size(); k++)
      if (txq[k] !== exp_byte(k, cyc)) errs++;
    chk({tag, "_seq_errs"}, errs, 0);
  endtask

  initial begin
    int pe0, pr0, n;
    link.rx_valid = 1'b0;
    link.rx_data  = 8'h00;
    eop_wb        = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_tx_valid", link.tx_valid, 1'b0);
    chk("rst_pipe_enable", pipe_enable, 1'b0);
    chk("rst_pipe_reset", pipe_reset, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_reg_addr", dbg_reg_addr, 5'd0);
    chk("rst_cycle_cnt", dut.cycle_cnt, 32'd0);
    reset = 1'b0;
    tick();

    // Single step, tx_ready always high
    txq.delete();
    pe0 = pe_cnt;
    send_byte(CMD_STEP);
    wait_done("t1");
    chk("t1_pe_cycles", pe_cnt - pe0, 1);
    check_dump("t1", 32'd1);
    chk("t1_pc_word", qword(0), 32'h0000_0004);
    chk("t1_cyc_word", qword(1), 32'h0000_0001);
    chk("t1_reg5_word", qword(2 + 5), 32'h0000_0005);
    chk("t1_mem2_word", qword(2 + NUM_REGS + 2), 32'h0000_0102);
    chk("t1_idle_halted", halted, 1'b0);

    // Restart, then continuous run with EOP 10 cycles in
    pr0 = pr_cnt;
    send_byte(CMD_RESTART);
    tick();
    chk("t2_restart_pulse", pr_cnt - pr0, 1);
    chk("t2_cnt_cleared", dut.cycle_cnt, 32'd0);
    txq.delete();
    pe0 = pe_cnt;
    send_byte(CMD_RUN);
    n = 0;
    while (!pipe_enable && n < 20) begin tick(); n++; end
    chk("t2_run_started", pipe_enable, 1'b1);
    repeat (10) tick();
    eop_wb = 1'b1;
    tick();
    eop_wb = 1'b0;
    wait_done("t2");
    chk("t2_pe_cycles", pe_cnt - pe0, 11);
    chk("t2_cyc_word", qword(1), 32'h0000_000B);
    chk("t2_nbytes", txq.size(), NBYTES);
    chk("t2_halted", halted, 1'b1);

    // HALTED: 'c' ignored, 'r' restarts; next step with stalling tx_ready
    pe0 = pe_cnt;
    send_byte(CMD_RUN);
    repeat (5) tick();
    chk("t3_c_ignored_pe", pe_cnt - pe0, 0);
    chk("t3_still_halted", halted, 1'b1);
    pr0 = pr_cnt;
    send_byte(CMD_RESTART);
    repeat (3) tick();
    chk("t3_restart_pulse", pr_cnt - pr0, 1);
    chk("t3_left_halted", halted, 1'b0);
    chk("t3_not_busy", busy, 1'b0);
    ready_mode = 1;
    txq.delete();
    send_byte(CMD_STEP);
    wait_done("t3");
    check_dump("t3", 32'd1);
    chk("t3_cyc_word", qword(1), 32'h0000_0001);
    chk("t3_ends_idle", halted, 1'b0);
    ready_mode = 0;

    // Ignored commands: junk in IDLE, 's'/junk while busy, rx on last byte
    pe0 = pe_cnt;
    send_byte(8'h41);
    repeat (3) tick();
    chk("t5_junk_idle_busy", busy, 1'b0);
    chk("t5_junk_idle_pe", pe_cnt - pe0, 0);
    txq.delete();
    send_byte(CMD_STEP);
    send_byte(CMD_STEP);
    send_byte(8'h41);
    n = 0;
    while (txq.size() < NBYTES && n < 3000) begin tick(); n++; end
    link.rx_valid = 1'b1;
    link.rx_data  = CMD_STEP;
    tick();
    link.rx_valid = 1'b0;
    repeat (20) tick();
    chk("t5_pe_cycles", pe_cnt - pe0, 1);
    chk("t5_nbytes", txq.size(), NBYTES);
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_halted", halted, 1'b0);

    // Reset in the middle of the register dump
    txq.delete();
    send_byte(CMD_STEP);
    n = 0;
    while (txq.size() < 40 && n < 3000) begin tick(); n++; end
    chk("t6_mid_dump_valid", link.tx_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk("t6_tx_valid", link.tx_valid, 1'b0);
    chk("t6_pipe_enable", pipe_enable, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_halted", halted, 1'b0);
    chk("t6_cycle_cnt", dut.cycle_cnt, 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    chk("stall_stability", stall_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
